// File: rtl/alu_result_stage_pkg.sv
// Shared opcode encodings and flag bit positions for the ALU result stage.
package alu_result_stage_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLTE = 4'd9
  } alu_op_e;

  localparam int FLAG_T = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status flags {V,N,Z,T} for one ALU result.
module alu_flag_gen
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_result,
  input  logic [3:0]       i_op,
  input  logic             i_overflow,
  output logic [3:0]       o_flags
);

  // NOTE: assigning a default first in always_comb prevents an inferred latch.
  always_comb begin
    o_flags         = '0;
    o_flags[FLAG_Z] = (i_result == '0);
    o_flags[FLAG_N] = i_result[WIDTH-1];
    // Overflow is meaningful only for arithmetic; undefined opcodes fall through as 0.
    o_flags[FLAG_V] = i_overflow && ((i_op == OP_ADD) || (i_op == OP_SUB));
    o_flags[FLAG_T] = (i_op == OP_SLTE) && i_result[0];
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: flag capture, 2-entry skid FIFO with a
// registered in_ready, and a saturating overflow counter.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_op,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             cnt_clr
);

  logic [WIDTH-1:0] r_res_mem  [2];
  logic [3:0]       r_flag_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_ovf_count;

  logic [3:0]       w_flags;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;
  logic             w_ovf_inc;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .i_result   (in_result),
    .i_op       (in_op),
    .i_overflow (in_overflow),
    .o_flags    (w_flags)
  );

  assign w_push      = in_valid && r_in_ready;
  assign w_pop       = (r_count != 2'd0) && out_ready;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_ovf_inc   = w_push && w_flags[FLAG_V] && (r_ovf_count != {CNT_W{1'b1}});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_ovf_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      // Ready looks at next occupancy only, so out_ready never reaches in_ready combinationally.
      r_in_ready <= (w_count_nxt < 2'd2);
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (cnt_clr)        r_ovf_count <= '0;
      else if (w_ovf_inc) r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

  // NOTE: storage has no reset; occupancy gates everything read from it.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_res_mem[r_wr_ptr]  <= in_result;
      r_flag_mem[r_wr_ptr] <= w_flags;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_count != 2'd0);
  assign out_result = out_valid ? r_res_mem[r_rd_ptr]  : '0;
  assign out_flags  = out_valid ? r_flag_mem[r_rd_ptr] : 4'd0;
  assign ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed plus random bench for alu_result_stage against a queue-based model.
module tb_alu_result_stage;
  import alu_result_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [3:0]  in_op;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic [7:0]  ovf_count;
  logic        cnt_clr;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(16), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_op       (in_op),
    .in_overflow (in_overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .ovf_count   (ovf_count),
    .cnt_clr     (cnt_clr)
  );

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flags;
  } ent_t;

  ent_t q[$];
  bit   m_ready = 1'b1;
  int   m_cnt   = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic logic [3:0] ref_flags(logic [15:0] r, logic [3:0] op, logic ov);
    bit v, n, z, t;
    v = ov && (op == 4'd0 || op == 4'd1);
    n = (r >= 16'h8000);
    z = (r == 16'd0);
    t = (op == 4'd9) && (r % 2 == 1);
    return {v, n, z, t};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_model(string tag);
    ent_t head;
    head = (q.size() > 0) ? q[0] : '0;
    check({tag, ".valid"},  32'(out_valid),  32'(q.size() > 0));
    check({tag, ".result"}, 32'(out_result), 32'(head.res));
    check({tag, ".flags"},  32'(out_flags),  32'(head.flags));
    check({tag, ".ready"},  32'(in_ready),   32'(m_ready));
    check({tag, ".cnt"},    32'(ovf_count),  32'(m_cnt));
  endtask

  task automatic step(string tag, logic v, logic [15:0] r, logic [3:0] op, logic ov,
                      logic ordy, logic clr, logic rs);
    bit push, pop;
    logic [3:0] f;
    rst = rs; in_valid = v; in_result = r; in_op = op; in_overflow = ov;
    out_ready = ordy; cnt_clr = clr;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ready = 1'b1;
      m_cnt = 0;
    end else begin
      push = v && m_ready;
      pop  = (q.size() > 0) && ordy;
      f    = ref_flags(r, op, ov);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({r, f});
      m_ready = (q.size() < 2);
      if (clr) m_cnt = 0;
      else if (push && f[3] && m_cnt < 255) m_cnt++;
    end
    #1;
    compare_model(tag);
  endtask

  initial begin
    // Reset and idle state
    step("rst0", 1, 16'hFFFF, OP_ADD, 1, 1, 0, 1);
    step("rst1", 0, 16'h0, OP_ADD, 0, 0, 0, 1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_cnt", 32'(ovf_count), 32'd0);

    // ADD 8000 with overflow
    step("add", 1, 16'h8000, OP_ADD, 1, 1, 0, 0);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_result", 32'(out_result), 32'h8000);
    check("add_flags", 32'(out_flags), 32'b1100);
    check("add_cnt", 32'(ovf_count), 32'd1);

    // SLTE true then false, in order
    step("slte1", 1, 16'h0001, OP_SLTE, 0, 1, 0, 0);
    check("slte1_flags", 32'(out_flags), 32'b0001);
    step("slte0", 1, 16'h0000, OP_SLTE, 0, 1, 0, 0);
    check("slte0_flags", 32'(out_flags), 32'b0010);
    step("drain0", 0, 16'h0, OP_ADD, 0, 1, 0, 0);
    check("drain0_valid", 32'(out_valid), 32'd0);
    check("empty_result", 32'(out_result), 32'd0);

    // Back-pressure: A, B accepted, C rejected
    step("pa", 1, 16'h1111, OP_OR, 0, 0, 0, 0);
    step("pb", 1, 16'h2222, OP_OR, 0, 0, 0, 0);
    check("full_ready", 32'(in_ready), 32'd0);
    step("pc", 1, 16'h3333, OP_OR, 0, 0, 0, 0);
    check("hold_a", 32'(out_result), 32'h1111);
    step("pop_a", 0, 16'h0, OP_OR, 0, 1, 0, 0);
    check("pop_a_ready", 32'(in_ready), 32'd1);
    check("pop_a_next", 32'(out_result), 32'h2222);
    step("pop_b", 0, 16'h0, OP_OR, 0, 1, 0, 0);
    check("pop_b_empty", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at occupancy 1
    step("px", 1, 16'h0A0A, OP_XOR, 0, 0, 0, 0);
    step("pxy", 1, 16'h0B0B, OP_SRL, 0, 1, 0, 0);
    check("pp_result", 32'(out_result), 32'h0B0B);
    check("pp_valid", 32'(out_valid), 32'd1);

    // Logic op with overflow asserted: V masked
    step("and", 1, 16'h0000, OP_AND, 1, 1, 0, 0);
    check("and_flags", 32'(out_flags), 32'b0010);
    check("and_cnt", 32'(ovf_count), 32'd1);

    // Saturation, clear priority
    for (int i = 0; i < 300; i++)
      step("sub_sat", 1, 16'($urandom), OP_SUB, 1, 1, 0, 0);
    check("sat_cnt", 32'(ovf_count), 32'd255);
    step("clr", 1, 16'h1234, OP_SUB, 1, 1, 1, 0);
    check("clr_cnt", 32'(ovf_count), 32'd0);

    // Reset while full
    step("f1", 1, 16'h00F1, OP_ADD, 1, 0, 0, 0);
    step("f2", 1, 16'h00F2, OP_ADD, 1, 0, 0, 0);
    check("f2_ready", 32'(in_ready), 32'd0);
    step("rst_full", 1, 16'h00F3, OP_ADD, 1, 1, 0, 1);
    check("rstf_valid", 32'(out_valid), 32'd0);
    check("rstf_ready", 32'(in_ready), 32'd1);
    check("rstf_cnt", 32'(ovf_count), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step("rand", 1'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
           1'($urandom), 1'($urandom), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 99) == 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
